// File: rtl/snake_tick_ctrl_if.sv
// Button/Start/GameOver/Length inputs and the Step/Dir/Ack/status outputs
// exchanged between the pace controller and its environment.
interface snake_tick_ctrl_if;
  logic       BtnL;
  logic       BtnR;
  logic       BtnU;
  logic       BtnD;
  logic       Start;
  logic       GameOver;
  logic [3:0] Length;
  logic       Step;
  logic [1:0] Dir;
  logic       Ack;
  logic       Running;
  logic       Paused;

  modport master (
    output BtnL, BtnR, BtnU, BtnD, Start, GameOver, Length,
    input  Step, Dir, Ack, Running, Paused
  );

  modport slave (
    input  BtnL, BtnR, BtnU, BtnD, Start, GameOver, Length,
    output Step, Dir, Ack, Running, Paused
  );
endinterface

// File: rtl/snake_tick_ctrl.sv
// Game-pace scheduler: length-dependent Step pulses, one committed direction
// per tick with reversal rejection, start/pause/ack sequencing.
module snake_tick_ctrl #(
  parameter int CNT_W     = 26,
  parameter int TICK_BASE = 25000000,
  parameter int TICK_STEP = 1000000,
  parameter int TICK_MIN  = 5000000
) (
  input logic              Clk,
  input logic              Reset,
  snake_tick_ctrl_if.slave bus
);
  localparam int PW = CNT_W + 4;
  localparam logic [PW-1:0] BASE = PW'(TICK_BASE);
  localparam logic [PW-1:0] PMIN = PW'(TICK_MIN);

  typedef enum logic [1:0] {IDLE, ACK, RUN, PAUSED} state_t;

  state_t          state, next_state;
  logic [4:0]      btn_now, btn_prev, btn_rise;
  logic            start_rise;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]   per_q, per_calc, dec;
  logic [1:0]      dir_q, pend_q;
  logic            pend_vld;
  logic            req_vld, accept, tick;
  logic [1:0]      req_dir;
  logic            step_d, ack_d, run_d, pause_d;
  logic            step_q, ack_q, run_q, pause_q;

  assign btn_now    = {bus.Start, bus.BtnD, bus.BtnU, bus.BtnR, bus.BtnL};
  assign btn_rise   = btn_now & ~btn_prev;
  assign start_rise = btn_rise[4];

  // Saturating period: never lets BASE - dec wrap below TICK_MIN.
  assign dec      = PW'(bus.Length) * PW'(TICK_STEP);
  assign per_calc = (dec < BASE && (BASE - dec) > PMIN) ? (BASE - dec) : PMIN;

  assign tick = (state == RUN) && !bus.GameOver && !start_rise &&
                ({4'b0, cnt_q} == per_q - PW'(1));

  always_comb begin
    req_vld = 1'b0;
    req_dir = 2'b00;
    if (btn_rise[0])      begin req_vld = 1'b1; req_dir = 2'b00; end
    else if (btn_rise[1]) begin req_vld = 1'b1; req_dir = 2'b01; end
    else if (btn_rise[2]) begin req_vld = 1'b1; req_dir = 2'b10; end
    else if (btn_rise[3]) begin req_vld = 1'b1; req_dir = 2'b11; end
  end

  // Opposite directions differ only in bit 0; check against the committed Dir.
  assign accept = (state == RUN) && req_vld && (req_dir != (dir_q ^ 2'b01));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_rise) next_state = ACK;
      ACK:     next_state = bus.GameOver ? IDLE : RUN;
      RUN:     if (bus.GameOver) next_state = IDLE;
               else if (start_rise) next_state = PAUSED;
      PAUSED:  if (bus.GameOver) next_state = IDLE;
               else if (start_rise) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    step_d  = tick;
    ack_d   = (next_state == ACK);
    run_d   = (next_state == RUN);
    pause_d = (next_state == PAUSED);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      btn_prev <= '0;
      cnt_q    <= '0;
      per_q    <= BASE;
      dir_q    <= 2'b01;
      pend_q   <= 2'b00;
      pend_vld <= 1'b0;
      step_q   <= 1'b0;
      ack_q    <= 1'b0;
      run_q    <= 1'b0;
      pause_q  <= 1'b0;
    end else begin
      btn_prev <= btn_now;
      step_q   <= step_d;
      ack_q    <= ack_d;
      run_q    <= run_d;
      pause_q  <= pause_d;
      if (state != IDLE && bus.GameOver) begin
        cnt_q    <= '0;
        pend_vld <= 1'b0;
      end else if (state == ACK) begin
        cnt_q    <= '0;
        pend_vld <= 1'b0;
        dir_q    <= 2'b01;
        per_q    <= per_calc;
      end else if (tick) begin
        cnt_q    <= '0;
        per_q    <= per_calc;
        if (pend_vld) dir_q <= pend_q;
        // An edge landing in the wrap cycle belongs to the next tick.
        pend_vld <= accept;
        if (accept) pend_q <= req_dir;
      end else begin
        if (state == RUN && !start_rise) cnt_q <= cnt_q + CNT_W'(1);
        if (accept) begin
          pend_q   <= req_dir;
          pend_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.Step    = step_q;
  assign bus.Dir     = dir_q;
  assign bus.Ack     = ack_q;
  assign bus.Running = run_q;
  assign bus.Paused  = pause_q;
endmodule

// File: tb/tb_snake_tick_ctrl.sv
// Scenario bench: expected Step/Ack events are queued with their cycle and
// direction, and matched when the pulses appear.
module tb_snake_tick_ctrl;
  logic Clk;
  logic Reset;
  snake_tick_ctrl_if bus();

  snake_tick_ctrl #(
    .CNT_W(8), .TICK_BASE(20), .TICK_STEP(2), .TICK_MIN(6)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] dir;
  } step_ev_t;

  step_ev_t step_exp[$];
  int       ack_exp[$];
  step_ev_t mon_ev;
  int       mon_ack;
  int       cyc = 0;
  int       n_chk = 0;
  int       n_fail = 0;
  int       e, c2;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic push_step(input int t, input logic [1:0] d);
    step_ev_t ev;
    ev.cyc = t;
    ev.dir = d;
    step_exp.push_back(ev);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_step"}, 32'(bus.Step), 0);
    chk({tag, "_dir"},  32'(bus.Dir), 1);
    chk({tag, "_ack"},  32'(bus.Ack), 0);
    chk({tag, "_run"},  32'(bus.Running), 0);
    chk({tag, "_pause"}, 32'(bus.Paused), 0);
  endtask

  always @(negedge Clk) begin
    if (bus.Step === 1'b1) begin
      if (step_exp.size() == 0) chk("step_extra", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        mon_ev = step_exp.pop_front();
        chk("step_cyc", 32'(cyc), 32'(mon_ev.cyc));
        chk("step_dir", 32'(bus.Dir), 32'(mon_ev.dir));
      end
    end
    if (bus.Ack === 1'b1) begin
      if (ack_exp.size() == 0) chk("ack_extra", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        mon_ack = ack_exp.pop_front();
        chk("ack_cyc", 32'(cyc), 32'(mon_ack));
      end
    end
  end

  initial begin
    Reset = 1'b1;
    bus.BtnL = 0; bus.BtnR = 0; bus.BtnU = 0; bus.BtnD = 0;
    bus.Start = 0; bus.GameOver = 0; bus.Length = 4'd0;
    at(2);
    chk_reset_vals("rst");
    Reset = 1'b0;

    // Start held 5 cycles: one Ack, RUN two cycles after the edge is driven.
    at(5);
    bus.Start = 1;
    ack_exp.push_back(6);
    e = 7;
    push_step(e + 20, 2'b01);   // L reversal discarded
    push_step(e + 40, 2'b11);   // U then D, last wins
    push_step(e + 60, 2'b11);   // held
    push_step(e + 80, 2'b00);   // L from down
    push_step(e + 100, 2'b10);  // U
    push_step(e + 120, 2'b00);  // L and U together, L wins
    push_step(e + 134, 2'b00);  // Length 3 -> P=14
    push_step(e + 140, 2'b00);  // Length 10 -> P=6 saturated
    push_step(e + 146, 2'b00);
    push_step(e + 183, 2'b00);  // resumed from counter 8
    push_step(e + 203, 2'b00);
    at(10);
    bus.Start = 0;
    chk("run_on", 32'(bus.Running), 1);
    chk("ack_off", 32'(bus.Ack), 0);

    at(e + 5);  bus.BtnL = 1;
    at(e + 6);  bus.BtnL = 0;
    at(e + 25); bus.BtnU = 1;
    at(e + 26); bus.BtnU = 0;
    at(e + 27); bus.BtnD = 1;
    at(e + 28); bus.BtnD = 0;
    at(e + 65); bus.BtnL = 1;
    at(e + 66); bus.BtnL = 0;
    at(e + 85); bus.BtnU = 1;
    at(e + 86); bus.BtnU = 0;
    at(e + 105); bus.BtnL = 1; bus.BtnU = 1; bus.Length = 4'd3;
    at(e + 106); bus.BtnL = 0; bus.BtnU = 0;
    at(e + 125); bus.Length = 4'd10;
    chk("dir_mid", 32'(bus.Dir), 0);
    at(e + 141); bus.Length = 4'd0;

    // Pause with counter at 8; a U edge while paused must be ignored.
    at(e + 154); bus.Start = 1;
    at(e + 156); bus.Start = 0;
    at(e + 158); bus.BtnU = 1;
    at(e + 159); bus.BtnU = 0;
    at(e + 160);
    chk("paused", 32'(bus.Paused), 1);
    chk("run_off_p", 32'(bus.Running), 0);
    at(e + 170); bus.Start = 1;
    at(e + 172); bus.Start = 0;
    chk("resumed", 32'(bus.Running), 1);
    chk("unpaused", 32'(bus.Paused), 0);

    // GameOver + Start edge exactly on the wrap cycle.
    at(e + 222); bus.GameOver = 1; bus.Start = 1;
    at(e + 224);
    chk("go_run", 32'(bus.Running), 0);
    chk("go_pause", 32'(bus.Paused), 0);
    chk("go_ack", 32'(bus.Ack), 0);
    bus.GameOver = 0; bus.Start = 0;

    c2 = e + 230;
    at(c2); bus.Start = 1;
    ack_exp.push_back(c2 + 1);
    push_step(c2 + 22, 2'b01);
    at(c2 + 3);
    chk("restart_dir", 32'(bus.Dir), 1);
    chk("restart_run", 32'(bus.Running), 1);
    bus.Start = 0;
    at(c2 + 25); bus.BtnU = 1;
    at(c2 + 26); bus.BtnU = 0;

    // Asynchronous reset mid-tick.
    at(c2 + 30);
    #3 Reset = 1'b1;
    #1 chk_reset_vals("arst");
    at(c2 + 35); Reset = 1'b0;
    at(c2 + 80);
    chk_reset_vals("post");
    chk("step_left", 32'(step_exp.size()), 0);
    chk("ack_left", 32'(ack_exp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_tick_ctrl.md
Name: snake_tick_ctrl

Overview:
- Game-pace scheduler and direction arbiter that sits in front of the snake core.
- Converts raw button levels into one committed direction per game tick and rejects 180-degree reversals.
- Issues a one-cycle Step pulse at a period that shrinks as the snake grows, and generates the core's Ack pulse.
- Handles start and pause sequencing, and returns to idle when the core reports win or lose.

Parameters:
- CNT_W, 26: tick counter width.
- TICK_BASE, 25000000: tick period in Clk cycles at Length 0.
- TICK_STEP, 1000000: period reduction per unit of Length.
- TICK_MIN, 5000000: floor on the tick period.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- BtnL  input  1  left button level, already synchronized.
- BtnR  input  1  right button level.
- BtnU  input  1  up button level.
- BtnD  input  1  down button level.
- Start  input  1  start/pause button level.
- GameOver  input  1  level; high while the core is in WIN or LOSE.
- Length  input  4  current snake length from the core.
- Step  output  1  one-cycle pulse that advances the core by one move.
- Dir  output  2  committed direction: 00 left, 01 right, 10 up, 11 down.
- Ack  output  1  one-cycle pulse telling the core to start or restart.
- Running  output  1  high in the RUN state.
- Paused  output  1  high in the PAUSED state.

Behaviour:
- Clocking: one clock, Clk. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE, Dir=01, Step=0, Ack=0, Running=0, Paused=0, counter=0, pending request invalid, previous-button registers=0.
- Edge detection: a rising edge is level & ~prev, using registered prev for each button and for Start. A button held high produces exactly one request.
- States:
  - IDLE: a Start edge gives Ack=1 the next cycle, then RUN. On entry to RUN: counter=0, pending cleared, Dir=01.
  - RUN: counter increments each cycle. A Start edge moves to PAUSED.
  - PAUSED: counter frozen, pending request kept, direction edges ignored. A Start edge returns to RUN and the counter resumes from its frozen value.
  - Any state except IDLE: GameOver=1 forces IDLE next cycle. Step is suppressed in that cycle, and pending and counter are cleared.
  - GameOver has priority over a Start edge in the same cycle.
- Direction arbitration (RUN only):
  - Simultaneous edges are resolved by fixed priority L > R > U > D.
  - The winner is compared against the committed Dir, not the pending value. L vs R and U vs D count as reversals; a reversal is discarded and pending is left unchanged.
  - An accepted request overwrites any earlier pending request, so the last accepted request wins.
- Tick period: P = max(TICK_MIN, TICK_BASE - Length*TICK_STEP).
  - Compute in CNT_W+4 bits and saturate at TICK_MIN with no underflow.
  - P is sampled at each counter wrap; a Length change mid-tick takes effect on the next tick.
- Tick:
  - When counter == P-1 in RUN: Step=1 for that one cycle, counter=0.
  - In the same edge, Dir takes the pending value if it is valid, and pending is cleared.
  - Dir is therefore stable whenever Step=1 and changes only together with Step.
  - A direction edge arriving in the wrap cycle counts toward the next tick.
  - With no input, Dir is held.
- Ack: high only for the single cycle after an IDLE Start edge, and never in RUN or PAUSED.
- Reset mid-tick or mid-pause: returns immediately to the reset values, with no residual Step or Ack.

Test Plan (TICK_BASE=20, TICK_STEP=2, TICK_MIN=6):
- Reset, then Start held high for 5 cycles -> Ack exactly 1 cycle, Running=1. With Length=0, the first Step comes 20 cycles after entering RUN and Steps repeat every 20 cycles with Dir=01.
- In RUN with Dir=01: press BtnL -> discarded, Dir stays 01. Press BtnU then BtnD within one tick -> the D edge is the later accepted request, so after the next Step Dir=11.
- BtnL and BtnU rising in the same cycle, Dir=10 -> L wins and is accepted; Dir=00 after the next Step.
- Length=3 -> period 14. Length=10 -> period 6 (saturated). Change Length from 3 to 10 mid-tick -> the current tick stays 14 and the next is 6.
- Start edge at counter=8 -> Paused=1, no Step, and a BtnU edge while paused is ignored. Second Start edge -> the next Step comes 12 cycles later (P=20), Dir unchanged.
- GameOver asserted in the same cycle as counter==P-1 and a Start edge -> no Step, state IDLE, Ack=0. A later Start edge -> Ack pulse and Dir=01. Assert Reset during RUN -> all outputs return to their reset values asynchronously.
